rr_grant_scheduler: RTL and testbench

- Round-robin scheduler that shares one resource among 16 requesters.
- Each cycle it picks the next requester in rotation and holds a registered one-hot grant until that requester releases or a hold timeout expires.
- The one-hot grant vector is produced by a 4-to-16 one-hot decoder driven from the registered grant index.
- Sits in front of any 16-way shared datapath or bus and supplies both the select index and the one-hot enables.

---
 rtl/rr_sched_pkg.sv | 33 +++
 rtl/onehot_dec16.sv | 15 +
 rtl/rr_grant_scheduler.sv | 92 +++++++++
 tb/tb_rr_grant_scheduler.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rr_sched_pkg.sv
// Shared constants, state encoding and the rotating-priority search
// used by the 16-way round-robin grant scheduler.
package rr_sched_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // First set request bit found searching upward from last_idx+1, wrapping;
  // last_idx itself is examined last.
  function automatic logic [IDX_W-1:0] next_rr(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] last_idx);
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    logic             found;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = last_idx + IDX_W'(i);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/onehot_dec16.sv
// 4-to-16 one-hot decoder with enable; output is all zero when disabled.
module onehot_dec16
  import rr_sched_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler for 16 requesters: registered grant index with a
// one-hot grant decoded from it, hold timeout, and a dead cycle between grants.
module rr_grant_scheduler
  import rr_sched_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam logic [IDX_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : IDX_W'(MAX_HOLD - 1);

  // Handshake: req is a level per requester; a grant lasts while req[grant_idx]
  // stays high (bounded by MAX_HOLD) and ends the cycle after it falls.
  state_t           state, state_nxt;
  logic [IDX_W-1:0] hold_cnt, hold_nxt;
  logic [IDX_W-1:0] last_idx, last_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             valid_nxt;
  logic             timeout_nxt;
  logic [IDX_W-1:0] winner;
  logic             expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      last_idx    <= IDX_W'(N_REQ - 1);
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      last_idx    <= last_nxt;
      grant_idx   <= idx_nxt;
      grant_valid <= valid_nxt;
      timeout     <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    last_nxt    = last_idx;
    idx_nxt     = grant_idx;
    valid_nxt   = grant_valid;
    timeout_nxt = 1'b0;
    winner      = next_rr(req, last_idx);
    expired     = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    case (state)
      S_IDLE, S_GAP: begin
        valid_nxt = 1'b0;
        state_nxt = S_IDLE;
        if (|req) begin
          state_nxt = S_GRANT;
          idx_nxt   = winner;
          valid_nxt = 1'b1;
          hold_nxt  = '0;
        end
      end
      S_GRANT: begin
        // A release takes precedence over expiry, so timeout only flags revocation.
        if (!req[grant_idx] || expired) begin
          state_nxt   = S_GAP;
          valid_nxt   = 1'b0;
          last_nxt    = grant_idx;
          timeout_nxt = req[grant_idx];
        end else if (hold_cnt != '1) begin
          hold_nxt = hold_cnt + IDX_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  onehot_dec16 u_dec (
    .idx    (grant_idx),
    .en     (grant_valid),
    .onehot (grant)
  );

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler: three instances with MAX_HOLD of 8, 4 and 0.
module tb_rr_grant_scheduler;

  logic        clk;
  logic        rst;
  logic [15:0] req8, req4, req0;
  logic [15:0] grant8, grant4, grant0;
  logic [3:0]  idx8, idx4, idx0;
  logic        valid8, valid4, valid0;
  logic        to8, to4, to0;

  int vectors = 0;
  int errors  = 0;

  rr_grant_scheduler #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .rst(rst), .req(req8), .grant(grant8),
    .grant_idx(idx8), .grant_valid(valid8), .timeout(to8));

  rr_grant_scheduler #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .grant(grant4),
    .grant_idx(idx4), .grant_valid(valid4), .timeout(to4));

  rr_grant_scheduler #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .grant(grant0),
    .grant_idx(idx0), .grant_valid(valid0), .timeout(to0));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // advance one edge; outputs are then stable for sampling
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req8 = '0; req4 = '0; req0 = '0;
    cycle();
    cycle();
    rst = 1'b0;
    vectors++; if (grant8 !== 16'h0000) begin errors++; $display("FAIL reset_grant8: got %h want 0000", grant8); end
    vectors++; if (idx8 !== 4'd0) begin errors++; $display("FAIL reset_idx8: got %0d want 0", idx8); end
    vectors++; if (valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid8: got %b want 0", valid8); end
    vectors++; if (to8 !== 1'b0) begin errors++; $display("FAIL reset_timeout8: got %b want 0", to8); end
    vectors++; if (grant4 !== 16'h0000 || grant0 !== 16'h0000) begin errors++; $display("FAIL reset_grant40: got %h %h want 0000 0000", grant4, grant0); end
  endtask

  task automatic test_single_release();
    req8 = 16'h0001;
    for (int k = 0; k < 3; k++) begin
      cycle();
      vectors++; if (grant8 !== 16'h0001) begin errors++; $display("FAIL single_grant c=%0d: got %h want 0001", k, grant8); end
      vectors++; if (valid8 !== 1'b1 || idx8 !== 4'd0) begin errors++; $display("FAIL single_valid c=%0d: got %b/%0d want 1/0", k, valid8, idx8); end
    end
    req8 = 16'h0000;
    cycle();
    vectors++; if (grant8 !== 16'h0000 || valid8 !== 1'b0) begin errors++; $display("FAIL single_gap: got %h/%b want 0000/0", grant8, valid8); end
    vectors++; if (idx8 !== 4'd0 || to8 !== 1'b0) begin errors++; $display("FAIL single_gap_idx: got %0d/%b want 0/0", idx8, to8); end
    cycle();
    vectors++; if (grant8 !== 16'h0000 || idx8 !== 4'd0) begin errors++; $display("FAIL single_idle: got %h/%0d want 0000/0", grant8, idx8); end
  endtask

  task automatic test_rotation();
    logic [15:0] exp_g;
    apply_reset();
    req8 = 16'hFFFF;
    for (int g = 0; g < 17; g++) begin
      exp_g = 16'h0001 << (g % 16);
      for (int c = 0; c < 8; c++) begin
        cycle();
        vectors++; if (grant8 !== exp_g || idx8 !== 4'(g % 16)) begin errors++; $display("FAIL rot_grant g=%0d c=%0d: got %h/%0d want %h/%0d", g, c, grant8, idx8, exp_g, g % 16); end
        vectors++; if (to8 !== 1'b0) begin errors++; $display("FAIL rot_no_timeout g=%0d c=%0d: got %b want 0", g, c, to8); end
      end
      cycle();
      vectors++; if (grant8 !== 16'h0000 || valid8 !== 1'b0) begin errors++; $display("FAIL rot_gap g=%0d: got %h/%b want 0000/0", g, grant8, valid8); end
      vectors++; if (to8 !== 1'b1 || idx8 !== 4'(g % 16)) begin errors++; $display("FAIL rot_timeout g=%0d: got %b/%0d want 1/%0d", g, to8, idx8, g % 16); end
    end
    req8 = 16'h0000;
    cycle();
  endtask

  task automatic test_wrap();
    apply_reset();
    req8 = 16'h4000;
    cycle();
    vectors++; if (grant8 !== 16'h4000) begin errors++; $display("FAIL wrap_setup: got %h want 4000", grant8); end
    req8 = 16'h0000;
    cycle();
    cycle();
    req8 = 16'h4001;
    cycle();
    vectors++; if (grant8 !== 16'h0001 || idx8 !== 4'd0) begin errors++; $display("FAIL wrap_first: got %h/%0d want 0001/0", grant8, idx8); end
    req8 = 16'h4000;
    cycle();
    vectors++; if (grant8 !== 16'h0000 || to8 !== 1'b0) begin errors++; $display("FAIL wrap_gap: got %h/%b want 0000/0", grant8, to8); end
    cycle();
    vectors++; if (grant8 !== 16'h4000 || idx8 !== 4'd14) begin errors++; $display("FAIL wrap_second: got %h/%0d want 4000/14", grant8, idx8); end
    req8 = 16'h0000;
    cycle();
    cycle();
  endtask

  task automatic test_reset_mid_grant();
    req8 = 16'h0020;
    cycle();
    vectors++; if (grant8 !== 16'h0020 || idx8 !== 4'd5) begin errors++; $display("FAIL mid_setup: got %h/%0d want 0020/5", grant8, idx8); end
    cycle();
    rst = 1'b1;
    cycle();
    vectors++; if (grant8 !== 16'h0000 || valid8 !== 1'b0) begin errors++; $display("FAIL mid_reset_grant: got %h/%b want 0000/0", grant8, valid8); end
    vectors++; if (to8 !== 1'b0 || idx8 !== 4'd0) begin errors++; $display("FAIL mid_reset_idx: got %b/%0d want 0/0", to8, idx8); end
    rst = 1'b0;
    req8 = 16'h0024;
    cycle();
    vectors++; if (grant8 !== 16'h0004 || idx8 !== 4'd2) begin errors++; $display("FAIL mid_first_after: got %h/%0d want 0004/2", grant8, idx8); end
    req8 = 16'h0000;
    cycle();
    cycle();
  endtask

  task automatic test_timeout_single();
    req4 = 16'h0200;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        cycle();
        vectors++; if (grant4 !== 16'h0200 || idx4 !== 4'd9 || to4 !== 1'b0) begin errors++; $display("FAIL to_grant r=%0d c=%0d: got %h/%0d/%b want 0200/9/0", r, c, grant4, idx4, to4); end
      end
      cycle();
      vectors++; if (grant4 !== 16'h0000 || to4 !== 1'b1) begin errors++; $display("FAIL to_gap r=%0d: got %h/%b want 0000/1", r, grant4, to4); end
    end
    req4 = 16'h0000;
    cycle();
    vectors++; if (grant4 !== 16'h0000 || to4 !== 1'b0) begin errors++; $display("FAIL to_idle: got %h/%b want 0000/0", grant4, to4); end
  endtask

  task automatic test_unlimited();
    req0 = 16'h0008;
    for (int c = 0; c < 100; c++) begin
      cycle();
      vectors++; if (grant0 !== 16'h0008 || to0 !== 1'b0) begin errors++; $display("FAIL unl_hold c=%0d: got %h/%b want 0008/0", c, grant0, to0); end
    end
    req0 = 16'h0000;
    cycle();
    vectors++; if (grant0 !== 16'h0000 || to0 !== 1'b0 || idx0 !== 4'd3) begin errors++; $display("FAIL unl_release: got %h/%b/%0d want 0000/0/3", grant0, to0, idx0); end
  endtask

  initial begin
    rst = 1'b1; req8 = '0; req4 = '0; req0 = '0;
    test_reset();
    test_single_release();
    test_rotation();
    test_wrap();
    test_reset_mid_grant();
    test_timeout_single();
    test_unlimited();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
